// File: rtl/aes_pkg.sv
// Shared AES definitions: FSM state type, round count, inverse S-box table and
// helpers that map (row, column) positions of the 4x4 state onto bit slices.
package aes_pkg;

    localparam int NR = 10;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ROUND,
        ST_FINAL,
        ST_DONE
    } aes_fsm_e;

    localparam logic [7:0] INV_SBOX [256] = '{
        8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
        8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
        8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
        8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
        8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
        8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
        8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
        8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
        8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
        8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
        8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
        8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
        8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
        8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
        8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
        8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
    };

    // Byte k = 4*col + row sits at [127-8k -: 8]; these return the slice LSB.
    function automatic int byte_lsb(input int row, input int col);
        return 120 - 8 * (4 * col + row);
    endfunction

    function automatic int col_lsb(input int col);
        return 96 - 32 * col;
    endfunction

endpackage

// File: rtl/inverseMixColumns.sv
// Combinational InvMixColumns over all four state columns (row 0 is the MSB byte).
module inverseMixColumns
    import aes_pkg::*;
(
    input  logic [127:0] data_i,
    output logic [127:0] data_o
);

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // GF(2^8) multiply by a 4-bit constant (0x09, 0x0b, 0x0d, 0x0e).
    function automatic logic [7:0] gmul(input logic [7:0] b, input logic [3:0] k);
        logic [7:0] p;
        logic [7:0] a;
        p = 8'h00;
        a = b;
        for (int i = 0; i < 4; i++) begin
            if (k[i]) p = p ^ a;
            a = xtime(a);
        end
        return p;
    endfunction

    for (genvar c = 0; c < 4; c++) begin : g_col
        logic [7:0] a0, a1, a2, a3;
        assign {a0, a1, a2, a3} = data_i[col_lsb(c) +: 32];
        assign data_o[col_lsb(c) +: 32] = {
            gmul(a0, 4'he) ^ gmul(a1, 4'hb) ^ gmul(a2, 4'hd) ^ gmul(a3, 4'h9),
            gmul(a0, 4'h9) ^ gmul(a1, 4'he) ^ gmul(a2, 4'hb) ^ gmul(a3, 4'hd),
            gmul(a0, 4'hd) ^ gmul(a1, 4'h9) ^ gmul(a2, 4'he) ^ gmul(a3, 4'hb),
            gmul(a0, 4'hb) ^ gmul(a1, 4'hd) ^ gmul(a2, 4'h9) ^ gmul(a3, 4'he)
        };
    end

endmodule

// File: rtl/inverse_sub_bytes.sv
// Combinational InvSubBytes: sixteen parallel inverse S-box lookups.
module inverse_sub_bytes
    import aes_pkg::*;
(
    input  logic [127:0] data_i,
    output logic [127:0] data_o
);

    for (genvar b = 0; b < 16; b++) begin : g_sbox
        assign data_o[8*b +: 8] = INV_SBOX[data_i[8*b +: 8]];
    end

endmodule

// File: rtl/aes_inv_cipher_iter.sv
// Iterative AES-128 inverse cipher: one decryption round per clock, round keys
// fetched combinationally from an external key-schedule store.
module aes_inv_cipher_iter #(
    parameter int NR = 10
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] ciphertext,
    output logic [3:0]   rk_addr,
    input  logic [127:0] rk_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] plaintext,
    output logic         busy
);
    import aes_pkg::*;

    localparam logic [3:0] LAST_RK = 4'(NR);

    aes_fsm_e     fsm_q, fsm_d;
    logic [127:0] state_q, state_d;
    logic [3:0]   round_q, round_d;

    logic [127:0] shifted, subbed, added, mixed;

    // InvShiftRows: row r rotates right by r, so s'[r][c] = s[r][(c-r) mod 4].
    always_comb begin
        shifted = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                shifted[byte_lsb(r, c) +: 8] = state_q[byte_lsb(r, (c - r + 4) % 4) +: 8];
            end
        end
    end

    inverse_sub_bytes u_inv_sub_bytes (
        .data_i (shifted),
        .data_o (subbed)
    );

    assign added = subbed ^ rk_data;

    inverseMixColumns u_inv_mix_columns (
        .data_i (added),
        .data_o (mixed)
    );

    always_comb begin
        fsm_d     = fsm_q;
        state_d   = state_q;
        round_d   = round_q;
        rk_addr   = LAST_RK;
        out_valid = 1'b0;
        case (fsm_q)
            ST_IDLE: begin
                if (in_valid) begin
                    state_d = ciphertext ^ rk_data;
                    round_d = LAST_RK - 4'd1;
                    fsm_d   = ST_ROUND;
                end
            end
            ST_ROUND: begin
                rk_addr = round_q;
                state_d = mixed;
                round_d = round_q - 4'd1;
                if (round_q == 4'd1) fsm_d = ST_FINAL;
            end
            ST_FINAL: begin
                rk_addr = 4'd0;
                state_d = added;
                fsm_d   = ST_DONE;
            end
            ST_DONE: begin
                out_valid = 1'b1;
                if (out_ready) fsm_d = ST_IDLE;
            end
            default: fsm_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fsm_q   <= ST_IDLE;
            state_q <= '0;
            round_q <= '0;
        end else begin
            fsm_q   <= fsm_d;
            state_q <= state_d;
            round_q <= round_d;
        end
    end

    // Held off while reset is asserted so a source never sees a phantom accept.
    assign in_ready  = (fsm_q == ST_IDLE) && rst_n;
    assign busy      = (fsm_q != ST_IDLE);
    assign plaintext = state_q;

endmodule

// File: tb/tb_aes_inv_cipher_iter.sv
// Scoreboard bench for aes_inv_cipher_iter: driver pushes expected plaintexts,
// a negedge monitor pops and compares on every out_valid/out_ready handshake.
module tb_aes_inv_cipher_iter;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] ciphertext;
    logic [3:0]   rk_addr;
    logic [127:0] rk_data;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] plaintext;
    logic         busy;

    always #5 clk = ~clk;

    aes_inv_cipher_iter #(.NR(10)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .ciphertext (ciphertext),
        .rk_addr    (rk_addr),
        .rk_data    (rk_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .plaintext  (plaintext),
        .busy       (busy)
    );

    localparam logic [127:0] K_C1  = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] PT_C1 = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT_C1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] K_B   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] RK10_B = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

    logic [127:0] rk_tab [0:10];
    logic [7:0]   sbox [256];
    logic [127:0] exp_q [$];
    int           checks = 0;
    int           errors = 0;
    bit           rand_sink = 1'b0;

    assign rk_data = (rk_addr <= 4'd10) ? rk_tab[rk_addr] : '0;

    // ---------------- reference model ----------------
    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xt(x);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        logic [7:0] r;
        r = (b << n) | (b >> (8 - n));
        return r;
    endfunction

    // Forward S-box built from the GF(2^8) inverse and the affine map.
    task automatic init_sbox();
        for (int x = 0; x < 256; x++) begin
            logic [7:0] inv;
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            sbox[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    task automatic expand_key(input logic [127:0] key);
        logic [31:0] w [44];
        logic [31:0] t;
        logic [7:0]  rc;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[96 - 32*i +: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sbox[t[31:24]], sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]]} ^ {rc, 24'h0};
                rc = xt(rc);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r <= 10; r++) rk_tab[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    function automatic logic [127:0] sub_shift(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                o[120 - 8*(4*c + r) +: 8] = sbox[s[120 - 8*(4*((c + r) % 4) + r) +: 8]];
        return o;
    endfunction

    function automatic logic [127:0] mix_cols(input logic [127:0] s);
        logic [127:0] o;
        logic [7:0]   a0, a1, a2, a3;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            {a0, a1, a2, a3} = s[96 - 32*c +: 32];
            o[96 - 32*c +: 32] = {gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3,
                                  a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3,
                                  a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03),
                                  gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02)};
        end
        return o;
    endfunction

    // Loads the schedule for key into rk_tab and returns the ciphertext of pt.
    task automatic encrypt(input logic [127:0] key, input logic [127:0] pt, output logic [127:0] ct);
        logic [127:0] s;
        expand_key(key);
        s = pt ^ rk_tab[0];
        for (int r = 1; r <= 9; r++) s = mix_cols(sub_shift(s)) ^ rk_tab[r];
        ct = sub_shift(s) ^ rk_tab[10];
    endtask

    // ---------------- checking ----------------
    task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: actual %0h required %0h", name, act, req);
        end
    endtask

    always @(negedge clk) begin
        if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_output: actual %0h required no output", plaintext);
            end else begin
                check("plaintext", plaintext, exp_q.pop_front());
            end
        end
    end

    // ---------------- driver helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
        if (rand_sink) out_ready = ($urandom_range(0, 3) != 0);
    endtask

    // Returns at a point where in_ready=1 with in_valid already high, so the next edge accepts.
    task automatic wait_ready();
        int n;
        n = 0;
        while (!in_ready && n < 60) begin
            tick();
            n++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: actual in_ready=0 required 1 within 60 cycles");
        end
    endtask

    task automatic wait_out_valid();
        int n;
        n = 0;
        while (!out_valid && n < 60) begin
            tick();
            n++;
        end
        if (!out_valid) begin
            checks++;
            errors++;
            $display("FAIL out_valid_timeout: actual 0 required 1 within 60 cycles");
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: actual timeout required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [127:0] ct, pt, key;
        logic [3:0]   rk_seq [0:10];
        int           lat, n, seen_ov;

        init_sbox();
        for (int r = 0; r <= 10; r++) rk_tab[r] = '0;
        rst_n      = 1'b0;
        in_valid   = 1'b0;
        ciphertext = '0;
        out_ready  = 1'b1;

        // Reset: in_ready must be forced low while rst_n=0 even though the FSM is IDLE.
        tick();
        tick();
        check("rst_in_ready_low", in_ready, 0);
        rst_n = 1'b1;
        #1;
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_plaintext", plaintext, 0);

        encrypt(K_C1, PT_C1, ct);
        check("model_c1_encrypt", ct, CT_C1);

        // FIPS-197 C.1 with latency and round-key address sequence.
        expand_key(K_C1);
        ciphertext = CT_C1;
        in_valid   = 1'b1;
        exp_q.push_back(PT_C1);
        wait_ready();
        rk_seq[0] = rk_addr;
        tick();
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 40) begin
            if (lat <= 10) rk_seq[lat] = rk_addr;
            tick();
            lat++;
        end
        check("c1_latency", lat, 11);
        for (int i = 0; i <= 10; i++) check($sformatf("c1_rk_addr_%0d", i), rk_seq[i], 10 - i);
        tick();

        // FIPS-197 Appendix B, including the state right after the initial AddRoundKey.
        expand_key(K_B);
        ciphertext = CT_B;
        in_valid   = 1'b1;
        exp_q.push_back(PT_B);
        wait_ready();
        tick();
        in_valid = 1'b0;
        check("b_state_t0", plaintext, CT_B ^ RK10_B);
        check("b_busy", busy, 1);
        wait_out_valid();
        tick();

        // Backpressure: five stalled DONE cycles.
        expand_key(K_C1);
        out_ready  = 1'b0;
        ciphertext = CT_C1;
        in_valid   = 1'b1;
        exp_q.push_back(PT_C1);
        wait_ready();
        tick();
        in_valid = 1'b0;
        wait_out_valid();
        for (int i = 0; i < 5; i++) begin
            check("bp_out_valid", out_valid, 1);
            check("bp_plaintext", plaintext, PT_C1);
            check("bp_in_ready", in_ready, 0);
            tick();
        end
        out_ready = 1'b1;
        tick();
        check("bp_release_busy", busy, 0);
        check("bp_release_in_ready", in_ready, 1);
        check("bp_release_out_valid", out_valid, 0);

        // Back-to-back with in_valid held high.
        ciphertext = CT_C1;
        in_valid   = 1'b1;
        exp_q.push_back(PT_C1);
        exp_q.push_back(PT_C1);
        wait_ready();
        tick();
        n = 1;
        while (!in_ready && n < 40) begin
            tick();
            n++;
        end
        check("b2b_period", n, 12);
        tick();
        in_valid = 1'b0;
        wait_out_valid();
        tick();

        // Reset mid-operation when rk_addr reaches 5.
        ciphertext = CT_C1;
        in_valid   = 1'b1;
        wait_ready();
        tick();
        in_valid = 1'b0;
        n = 0;
        while (rk_addr != 4'd5 && n < 20) begin
            tick();
            n++;
        end
        check("mid_rk_addr", rk_addr, 5);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        #1;
        check("mid_rst_busy", busy, 0);
        check("mid_rst_in_ready", in_ready, 1);
        check("mid_rst_plaintext", plaintext, 0);
        seen_ov = 0;
        for (int i = 0; i < 15; i++) begin
            if (out_valid) seen_ov++;
            tick();
        end
        check("mid_rst_no_out_valid", seen_ov, 0);
        ciphertext = CT_C1;
        in_valid   = 1'b1;
        exp_q.push_back(PT_C1);
        wait_ready();
        tick();
        in_valid = 1'b0;
        wait_out_valid();
        tick();

        // Random keys/plaintexts with random source gaps and sink stalls.
        rand_sink = 1'b1;
        for (int b = 0; b < 1000; b++) begin
            n = 0;
            while (busy && !out_valid && n < 40) begin
                tick();
                n++;
            end
            key = {$urandom, $urandom, $urandom, $urandom};
            pt  = {$urandom, $urandom, $urandom, $urandom};
            encrypt(key, pt, ct);
            for (int g = $urandom_range(0, 3); g > 0; g--) tick();
            ciphertext = ct;
            in_valid   = 1'b1;
            exp_q.push_back(pt);
            wait_ready();
            tick();
            in_valid = 1'b0;
        end
        n = 0;
        while (exp_q.size() != 0 && n < 400) begin
            tick();
            n++;
        end
        rand_sink = 1'b0;
        out_ready = 1'b1;
        check("queue_drained", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/aes_inv_cipher_iter.md
# aes_inv_cipher_iter

Iterative AES-128 inverse-cipher core. It takes one 128-bit ciphertext block, runs the ten decryption rounds at one round per clock, and returns the plaintext block. The core fetches round keys from an external key-schedule store through an address/data port. It contains the round datapath that feeds `inverseMixColumns` (InvShiftRows → InvSubBytes → AddRoundKey → InvMixColumns) and sits between the block-input interface and the plaintext sink.

## Interface
- `NR`, default 10: number of rounds. Fixed for AES-128; no other value is supported.
- `clk`  in  1: single clock, rising edge.
- `rst_n`  in  1: reset. Synchronous, active-low.
- `in_valid`  in  1: ciphertext block is valid.
- `in_ready`  out  1: core can accept a block.
- `ciphertext`  in  128: input block. Byte 0 is `[127:120]`. Column c occupies `[127-32c -: 32]`, with row 0 as the MSB byte of each word.
- `rk_addr`  out  4: round-key index, 0..10.
- `rk_data`  in  128: round key for `rk_addr`. Combinational: valid in the same cycle as `rk_addr`.
- `out_valid`  out  1: plaintext block is valid.
- `out_ready`  in  1: sink accepts the plaintext block.
- `plaintext`  out  128: result, in the same byte order as `ciphertext`.
- `busy`  out  1: high in every state except IDLE.

## Operation
- FSM states: IDLE, ROUND, FINAL, DONE. Registers: `state` (128 bits), `round` (4 bits).
- IDLE
  - `in_ready`=1 and `rk_addr`=10.
  - On `in_valid && in_ready`: `state` ← `ciphertext ^ rk_data`, `round` ← 9, go to ROUND.
- ROUND
  - `rk_addr`=`round`.
  - `state` ← InvMixColumns(InvSubBytes(InvShiftRows(`state`)) ^ `rk_data`).
  - `round` ← `round`−1.
  - When `round`==1, go to FINAL; otherwise stay in ROUND.
- FINAL
  - `rk_addr`=0.
  - `state` ← InvSubBytes(InvShiftRows(`state`)) ^ `rk_data`. No InvMixColumns.
  - Go to DONE.
- DONE
  - `out_valid`=1 and `plaintext`=`state`.
  - On `out_ready`, go to IDLE.
  - While `out_ready`=0, `plaintext` and `out_valid` hold.
- InvShiftRows: row r is rotated right by r byte positions, i.e. new `s[r][c]` = `s[r][(c−r) mod 4]`.
- `plaintext` is driven from `state` at all times. It is meaningful only while `out_valid`=1.
- `rk_addr` in DONE is don't-care. Drive 10.

## Timing
- Acceptance edge T0. Rounds 9..1 take edges T1..T9, FINAL takes T10, and `out_valid` rises in the cycle after T10.
- Latency is 11 cycles from acceptance to `out_valid`.
- Minimum block period is 12 cycles (DONE → IDLE → accept). `in_ready` is 0 during ROUND, FINAL and DONE.
- `rk_addr` sequence: 10 (at accept), 9, 8, …, 1, 0. One step per cycle, with no gaps.
- Reset (`rst_n`=0 at an edge):
  - FSM → IDLE, `round` ← 0, `state` ← 0.
  - Outputs after reset: `out_valid`=0, `busy`=0, `plaintext`=0.
  - `in_ready` is forced to 0 while `rst_n`=0 and is 1 in the first cycle after release.
- Reset during ROUND, FINAL or DONE abandons the block. No `out_valid` pulse is produced.
- `in_valid` asserted while not IDLE is ignored. The block is not latched, and the source must hold it.
- `in_valid` held high through DONE→IDLE: the next block is accepted in the first IDLE cycle.

## Structure
- Shared package `aes_pkg`:
  - state enum.
  - `NR`.
  - 256×8 inverse S-box constant.
  - Byte/column index helper functions (row/column ↔ bit slice).
- Sub-module `inverse_sub_bytes`: combinational, 128 bits in and out, 16 inverse S-box lookups. Instantiated once.
- Existing `inverseMixColumns` is instantiated once. InvShiftRows and AddRoundKey are inline wiring/XOR.

## Test plan
- FIPS-197 Appendix C.1:
  - Stimulus: key 000102030405060708090a0b0c0d0e0f via the bench key-schedule model, ciphertext 69c4e0d86a7b0430d8cdb78070b4c55a.
  - Required: `plaintext` 00112233445566778899aabbccddeeff, `out_valid` exactly 11 cycles after acceptance, `rk_addr` sequence 10..0.
- FIPS-197 Appendix B:
  - Stimulus: key 2b7e151628aed2a6abf7158809cf4f3c, ciphertext 3925841d02dc09fbdc118597196a0b32.
  - Required: `plaintext` 3243f6a8885a308d313198a2e0370734.
  - Also check the state after T0 equals ciphertext ^ d014f9a8c9ee2589e13f0cc8b6630ca6.
- Backpressure:
  - Stimulus: hold `out_ready`=0 for 5 cycles in DONE.
  - Required: `out_valid` stays 1, `plaintext` stable, `in_ready`=0. Returns to IDLE one cycle after `out_ready`=1.
- Back-to-back:
  - Stimulus: `in_valid` held high with two C.1 ciphertexts.
  - Required: second acceptance exactly 12 cycles after the first, and both plaintexts are correct.
- Reset mid-operation:
  - Stimulus: `rst_n`=0 for 1 cycle when `rk_addr`=5.
  - Required: no `out_valid`, `busy`=0 and `in_ready`=1 after release. A subsequent C.1 block decrypts correctly.
- Random:
  - Stimulus: 1000 random key/plaintext pairs, encrypted by the reference model, with random `in_valid`/`out_ready` gaps.
  - Required: every block matches the model in order.
